// File: rtl/mult_8bit_seq_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller:
// FSM state encoding, default operand/product widths and the step-counter
// width helper used by both the controller and the shared step datapath.
package mult_seq_pkg;

    // Default operand width and the matching full-precision product width.
    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_PROD_WIDTH = 2 * DEFAULT_WIDTH;

    // Controller states: waiting for operands, stepping, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_seq_state_e;

    // Width of the step counter that walks the multiplier bits 0..width-1.
    // Clamped to one bit so a degenerate width of 1 still yields a legal vector.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mult_8bit_seq_ctrl_shift_add_step.sv
// Single conditional shift-add step of the unsigned multiply.
// Purely combinational: given the multiplicand, the bit position being
// processed, that multiplier bit and the running partial sum, it returns the
// updated partial sum. The controller instantiates exactly one of these and
// reuses it on every RUN cycle.
module shift_add_step
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0]   x,
    input  logic [CNT_W-1:0]   shamt,
    input  logic               y_bit,
    input  logic [2*WIDTH-1:0] psum,
    output logic [2*WIDTH-1:0] new_sum
);

    // Multiplicand zero-extended to product width before shifting so no
    // high-order bits are lost for large shift amounts.
    logic [2*WIDTH-1:0] x_ext;
    logic [2*WIDTH-1:0] addend;

    assign x_ext  = {{WIDTH{1'b0}}, x};
    assign addend = x_ext << shamt;

    // Add the shifted multiplicand only when the current multiplier bit is set.
    // The sum of partial products of two WIDTH-bit unsigned values always fits
    // in 2*WIDTH bits, so the carry out is intentionally dropped.
    assign new_sum = psum + (y_bit ? addend : '0);

endmodule

// File: rtl/mult_8bit_seq_ctrl.sv
// Sequential 8-bit unsigned multiplier controller.
// Runs the shift-add multiply one step per clock against a single shared
// step datapath, walking the multiplier from LSB to MSB. Operands are taken
// through a valid/ready handshake in IDLE; the 2*WIDTH-bit product is offered
// through a valid/ready handshake in DONE and held until accepted.
//
// Build option:
//   MULT_SEQ_EARLY_TERM_EN - leave RUN as soon as the remaining multiplier
//   bits are all zero (at least one step always executes). The product is
//   identical; only the latency shrinks. Undefined: always WIDTH RUN cycles.
module mult_8bit_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int                 CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

    mult_seq_state_e    state;
    mult_seq_state_e    state_next;

    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   x_reg;
    logic [WIDTH-1:0]   y_reg;
    logic [2*WIDTH-1:0] step_sum;

    logic               accept;
    logic               handoff;
    logic               last_step;

    // Handshake qualifiers shared by the FSM and the datapath registers.
    assign accept  = in_valid  && in_ready;
    assign handoff = out_valid && out_ready;

    // The step that ends RUN: the final multiplier bit, or (with early
    // termination) the step after which no set multiplier bits remain.
`ifdef MULT_SEQ_EARLY_TERM_EN
    assign last_step = (cnt == LAST_CNT) || ((y_reg >> 1) == '0);
`else
    assign last_step = (cnt == LAST_CNT);
`endif

    // The one shared datapath step, fed by the current bit position and LSB.
    shift_add_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .x       (x_reg),
        .shamt   (cnt),
        .y_bit   (y_reg[0]),
        .psum    (acc),
        .new_sum (step_sum)
    );

    // State register; reset aborts any in-flight multiply back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept -> step WIDTH (or fewer) times -> hold result.
    always_comb begin
        // NOTE: the default assignment up front keeps every path assigned, so
        // no latch is inferred when a case arm leaves the state unchanged.
        state_next = state;
        unique case (state)
            IDLE: if (accept)    state_next = RUN;
            RUN:  if (last_step) state_next = DONE;
            DONE: if (handoff)   state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            RUN: begin
                in_ready = 1'b0;
            end
            DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
        endcase
    end

    // Datapath registers: capture operands on acceptance, then one shift-add
    // step per RUN cycle. x_reg is only ever written at acceptance, so input
    // changes after the handshake never reach the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        x_reg <= x;
                        y_reg <= y;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= step_sum;
                    y_reg <= y_reg >> 1;
                    cnt   <= cnt + CNT_W'(1);
                end
                default: begin
                    // DONE holds the accumulated product stable for the consumer.
                end
            endcase
        end
    end

    // The product is the accumulator register itself, so p is glitch-free and
    // cannot change while the result is stalled in DONE.
    assign p = acc;

endmodule
